// File: rtl/ysyx_23060061_bus_pkg.sv
// Shared bus definitions for the memory arbiter and future interconnect blocks.
// Holds the arbiter state encoding, default widths and master index constants.
package ysyx_23060061_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam int DEF_N_MASTERS = 2;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_TIMEOUT   = 255;

  localparam int MASTER_IFU = 0;
  localparam int MASTER_LSU = 1;

  // Index width that stays legal for single-entry vectors.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_23060061_rr_picker.sv
// Combinational round-robin priority encoder: first valid bit at or above ptr,
// wrapping modulo N. Standalone so crossbars can reuse it.
module ysyx_23060061_rr_picker
  import ysyx_23060061_bus_pkg::*;
#(
  parameter int N  = DEF_N_MASTERS,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin : pick
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && valid[j]) begin
        any       = 1'b1;
        idx       = IW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060061_mem_arbiter.sv
// N-master to 1-slave memory arbiter: round-robin grant, one outstanding
// transaction, payload latched at grant, response timeout into an error reply.
module ysyx_23060061_mem_arbiter
  import ysyx_23060061_bus_pkg::*;
#(
  parameter int N_MASTERS = DEF_N_MASTERS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_req_valid,
  output logic [N_MASTERS-1:0]          m_req_ready,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_req_addr,
  input  logic [N_MASTERS-1:0]          m_req_wen,
  input  logic [N_MASTERS*DATA_W-1:0]   m_req_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_req_wmask,
  output logic [N_MASTERS-1:0]          m_resp_valid,
  input  logic [N_MASTERS-1:0]          m_resp_ready,
  output logic [DATA_W-1:0]             m_resp_rdata,
  output logic                          m_resp_err,
  output logic                          s_req_valid,
  input  logic                          s_req_ready,
  output logic [ADDR_W-1:0]             s_req_addr,
  output logic                          s_req_wen,
  output logic [DATA_W-1:0]             s_req_wdata,
  output logic [DATA_W/8-1:0]           s_req_wmask,
  input  logic                          s_resp_valid,
  output logic                          s_resp_ready,
  input  logic [DATA_W-1:0]             s_resp_rdata,
  input  logic                          s_resp_err
);

  localparam int MW = DATA_W / 8;
  localparam int IW = idx_w(N_MASTERS);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MW-1:0]     wmask;
  } req_t;

  req_t [N_MASTERS-1:0] m_req;
  req_t                 req_q;
  arb_state_e           state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        grant;
  logic [TW-1:0]        to_cnt;
  logic                 s_req_valid_q;

  logic [N_MASTERS-1:0] pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic [N_MASTERS-1:0] grant_oh;
  logic                 in_resp;
  logic                 gr_ready;
  logic                 forced;
  logic                 resp_done;

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
    assign m_req[g] = '{addr:  m_req_addr[g*ADDR_W +: ADDR_W],
                        wen:   m_req_wen[g],
                        wdata: m_req_wdata[g*DATA_W +: DATA_W],
                        wmask: m_req_wmask[g*MW +: MW]};
  end

  ysyx_23060061_rr_picker #(.N(N_MASTERS), .IW(IW)) u_picker (
    .valid  (m_req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    grant_oh        = '0;
    grant_oh[grant] = 1'b1;
  end

  assign in_resp   = (state == ST_RESP);
  assign gr_ready  = m_resp_ready[grant];
  assign forced    = (TIMEOUT != 0) && in_resp && (to_cnt == TO_VAL);
  assign resp_done = in_resp && gr_ready && (forced || s_resp_valid);

  // Grant is offered combinationally; held low while reset is asserted.
  assign m_req_ready = (rst && state == ST_IDLE) ? pick_oh : '0;

  assign s_req_valid = s_req_valid_q;
  assign s_req_addr  = req_q.addr;
  assign s_req_wen   = req_q.wen;
  assign s_req_wdata = req_q.wdata;
  assign s_req_wmask = req_q.wmask;

  // A forced timeout reply masks the slave entirely so a late beat is not consumed.
  always_comb begin
    m_resp_valid = '0;
    m_resp_rdata = '0;
    m_resp_err   = 1'b0;
    s_resp_ready = 1'b0;
    if (in_resp) begin
      if (forced) begin
        m_resp_valid = grant_oh;
        m_resp_err   = 1'b1;
      end else begin
        m_resp_valid = s_resp_valid ? grant_oh : '0;
        m_resp_rdata = s_resp_rdata;
        m_resp_err   = s_resp_err;
        s_resp_ready = gr_ready;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      req_q         <= '0;
      s_req_valid_q <= 1'b0;
      to_cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            req_q         <= m_req[pick_idx];
            grant         <= pick_idx;
            s_req_valid_q <= 1'b1;
            state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (s_req_ready) begin
            s_req_valid_q <= 1'b0;
            to_cnt        <= '0;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_done) begin
            rr_ptr <= (grant == IW'(N_MASTERS - 1)) ? '0 : grant + IW'(1);
            state  <= ST_IDLE;
          end else if (TIMEOUT != 0 && !s_resp_valid && !forced) begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_23060061_mem_arbiter.md
Name: ysyx_23060061_mem_arbiter

Overview:
- Parametrised N-master to 1-slave memory arbiter with valid/ready request and response channels.
- Lets IFU, LSU and future masters share one memory/bus port, replacing the per-unit direct DPI memory access.
- Round-robin fairness, one outstanding transaction at a time, request payload buffered at grant.
- A response timeout turns a hung slave into an error response instead of stalling the core.

Parameters:
N_MASTERS, 2, number of requesting masters (>=2); index 0 = IFU, 1 = LSU.
ADDR_W, 32, address width.
DATA_W, 32, data width; byte mask width is DATA_W/8.
TIMEOUT, 255, maximum cycles waiting in RESP before a forced error response; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
m_req_valid  in  N_MASTERS  per-master request valid.
m_req_ready  out  N_MASTERS  per-master request accept.
m_req_addr  in  N_MASTERS*ADDR_W  packed; master i occupies slice [i*ADDR_W +: ADDR_W].
m_req_wen  in  N_MASTERS  1 = write, 0 = read.
m_req_wdata  in  N_MASTERS*DATA_W  packed write data.
m_req_wmask  in  N_MASTERS*DATA_W/8  packed byte strobes.
m_resp_valid  out  N_MASTERS  per-master response valid.
m_resp_ready  in  N_MASTERS  per-master response accept.
m_resp_rdata  out  DATA_W  shared read data; valid only for the master whose m_resp_valid bit is set.
m_resp_err  out  1  shared error flag (slave error or timeout).
s_req_valid  out  1  request to slave.
s_req_ready  in  1  slave accepts request.
s_req_addr  out  ADDR_W  slave address.
s_req_wen  out  1  slave write enable.
s_req_wdata  out  DATA_W  slave write data.
s_req_wmask  out  DATA_W/8  slave byte strobes.
s_resp_valid  in  1  slave response valid.
s_resp_ready  out  1  arbiter accepts the slave response.
s_resp_rdata  in  DATA_W  slave read data.
s_resp_err  in  1  slave error.

Behaviour:
- Reset, asserted asynchronously:
  - state = IDLE, rr_ptr = 0, grant = 0, timeout counter = 0.
  - All payload registers = 0.
  - All valid/ready outputs = 0; m_resp_rdata = 0; m_resp_err = 0.
  - Reset mid-transaction abandons the transaction. No response is produced afterwards, and a late s_resp_valid is ignored until a new grant exists.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Winner = first i with m_req_valid[i], searching from rr_ptr upward with wrap modulo N_MASTERS.
  - m_req_ready[winner] = 1 in the same cycle (combinational); all other bits are 0.
  - On that edge: latch addr, wen, wdata and wmask of the winner; grant = winner; go to REQ.
  - No valid request: stay in IDLE, all outputs 0.
- REQ:
  - s_req_valid = 1, payload driven from the latched registers (stable while waiting).
  - When s_req_valid & s_req_ready: go to RESP and clear the timeout counter.
  - All m_req_ready = 0; new requests wait.
- RESP:
  - s_resp_ready = m_resp_ready[grant].
  - m_resp_valid[grant] = s_resp_valid; other bits 0.
  - m_resp_rdata = s_resp_rdata; m_resp_err = s_resp_err.
  - On the s_resp_valid & m_resp_ready[grant] handshake: rr_ptr = (grant+1) mod N_MASTERS; go to IDLE.
  - Timeout counter increments each cycle without s_resp_valid. When it reaches TIMEOUT (TIMEOUT != 0):
    - force m_resp_valid[grant] = 1, m_resp_err = 1, m_resp_rdata = 0;
    - hold s_resp_ready = 0;
    - complete the transaction on m_resp_ready[grant] as above.
  - A slave response arriving during a forced response is not accepted.
- Minimum latency, request accept to response valid: 2 cycles (accept edge, slave-accept edge, response cycle), with zero-wait slave.
- Back-to-back: the next grant occurs in the IDLE cycle after completion; throughput is at most 1 transaction per 3 cycles.
- Fairness: a master just served has lowest priority next round. Simultaneous requests from all masters are served in rotation order.
- Requests are not dropped. A master holding valid while not granted keeps valid held, and its payload is sampled only at its own grant.
- Outputs are registered except m_req_ready and the RESP pass-through signals.

Decomposition:
- Shared package ysyx_23060061_bus_pkg holds:
  - state encoding (IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2);
  - default widths;
  - the index constants MASTER_IFU = 0 and MASTER_LSU = 1.
- One natural sub-module, ysyx_23060061_rr_picker:
  - combinational round-robin priority encoder;
  - inputs: valid vector, pointer;
  - outputs: one-hot winner, winner index, any.
  - Usable standalone by future crossbars.

Test Plan:
- Single read: N=2, master 1 reads 0x80000010; slave accepts immediately and returns 0xDEADBEEF one cycle later. Required: m_req_ready[1] pulses once, s_req_addr = 0x80000010 with s_req_wen = 0, m_resp_valid = 2'b10 with rdata 0xDEADBEEF, FSM back in IDLE.
- Contention: both masters are valid continuously for 4 transactions, rr_ptr = 0 after reset. Required: grant order 0, 1, 0, 1; no master served twice in a row.
- Write with backpressure: master 0 writes wdata 0x12345678 with wmask 4'b0101; s_req_ready is held 0 for 3 cycles. Required: s_req_* stay stable for all 3 cycles; exactly one slave handshake with the exact mask.
- Response backpressure: m_resp_ready[grant] low for 2 cycles while s_resp_valid is high. Required: s_resp_ready = 0 for those cycles; data stays visible; completion on the first cycle both are high.
- Timeout: TIMEOUT = 4 and the slave never responds. Required: after 4 RESP cycles m_resp_valid[grant] = 1, m_resp_err = 1, rdata = 0; then IDLE; rr_ptr advanced.
- Reset mid-RESP: rst driven low while in RESP. Required: all outputs are 0 immediately (asynchronously); after release, state IDLE and rr_ptr = 0; a stale s_resp_valid produces no m_resp_valid.
